// File: rtl/simt_pc_if.sv
// simt_pc_if: decoder/NZP inputs and PC/mask outputs of the block PC and divergence sequencer.
interface simt_pc_if #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int THREADS_PER_BLOCK = 4
);
   logic enable;
   logic [3:0] core_state;
   logic decoded_ssy;
   logic decoded_sync;
   logic decoded_ret;
   logic [2:0] decoded_nzp;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_immediate;
   logic [3*THREADS_PER_BLOCK-1:0] thread_nzp;
   logic [THREADS_PER_BLOCK-1:0] origin_mask;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc;
   logic [THREADS_PER_BLOCK-1:0] current_mask;
   logic [THREADS_PER_BLOCK-1:0] exec_mask;
   logic [1:0] div_state;
   logic done;
   logic nest_error;
   modport master (
      output enable, core_state, decoded_ssy, decoded_sync, decoded_ret, decoded_nzp,
             decoded_immediate, thread_nzp, origin_mask,
      input current_pc, current_mask, exec_mask, div_state, done, nest_error
   );
   modport slave (
      input enable, core_state, decoded_ssy, decoded_sync, decoded_ret, decoded_nzp,
            decoded_immediate, thread_nzp, origin_mask,
      output current_pc, current_mask, exec_mask, div_state, done, nest_error
   );
endinterface

// File: rtl/simt_pc_unit.sv
// simt_pc_unit: block PC, execution mask and SSY/SYNC divergence sequencing for one thread block.
module simt_pc_unit #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int THREADS_PER_BLOCK = 4
) (
   input logic clk,
   input logic reset,
   simt_pc_if.slave bus
);
   localparam int A = PROGRAM_MEM_ADDR_BITS;
   localparam int T = THREADS_PER_BLOCK;
   typedef enum logic [1:0] {CONV = 2'b00, TAKEN = 2'b01, FALL = 2'b10} div_t;
   div_t state, state_n;
   logic [A-1:0] pc, pc_n, fall_pc, fall_pc_n, pc_inc;
   logic [T-1:0] exec_mask, exec_mask_n, taken_saved, taken_saved_n, taken, fall_mask;
   logic done, done_n, nest_error, nest_error_n, upd;
   for (genvar i = 0; i < T; i++) begin : g_taken
      assign taken[i] = bus.origin_mask[i] & |(bus.thread_nzp[3*i +: 3] & bus.decoded_nzp);
   end
   assign pc_inc = pc + 1'b1;
   assign fall_mask = bus.origin_mask & ~taken_saved;
   assign upd = bus.core_state == 4'b0110 && bus.enable && !done;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CONV;
         pc <= '0;
         exec_mask <= '1;
         fall_pc <= '0;
         taken_saved <= '0;
         done <= 1'b0;
         nest_error <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         exec_mask <= exec_mask_n;
         fall_pc <= fall_pc_n;
         taken_saved <= taken_saved_n;
         done <= done_n;
         nest_error <= nest_error_n;
      end
   end
   always_comb begin
      state_n = state;
      pc_n = pc;
      exec_mask_n = exec_mask;
      fall_pc_n = fall_pc;
      taken_saved_n = taken_saved;
      done_n = done;
      nest_error_n = nest_error;
      if (upd) begin
         pc_n = pc_inc;
         if (bus.decoded_ssy) begin
            if (state != CONV) nest_error_n = 1'b1;
            else if (|taken) begin
               pc_n = bus.decoded_immediate;
               exec_mask_n = taken;
               taken_saved_n = taken;
               fall_pc_n = pc_inc;
               state_n = TAKEN;
            end else begin
               exec_mask_n = bus.origin_mask;
               state_n = FALL;
            end
         end else if (bus.decoded_sync) begin
            // the taken path returns to the fall-through code only if someone is waiting there
            if (state == TAKEN && |fall_mask) begin
               pc_n = fall_pc;
               exec_mask_n = fall_mask;
               state_n = FALL;
            end else if (state != CONV) begin
               pc_n = bus.decoded_immediate;
               exec_mask_n = bus.origin_mask;
               state_n = CONV;
            end
         end else if (bus.decoded_ret) begin
            if (state != CONV) nest_error_n = 1'b1;
            else begin
               done_n = 1'b1;
               pc_n = pc;
            end
         end
      end
   end
   assign bus.current_mask = taken;
   assign bus.current_pc = pc;
   assign bus.exec_mask = exec_mask;
   assign bus.div_state = state;
   assign bus.done = done;
   assign bus.nest_error = nest_error;
endmodule

// File: tb/tb_simt_pc_unit.sv
// tb_simt_pc_unit: directed SSY/SYNC/RET sequences with hand-computed PC, mask and state expectations.
module tb_simt_pc_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   localparam logic [11:0] NZP_MIX = 12'b100_001_010_001;
   localparam logic [11:0] NZP_ALLP = 12'b001_001_001_001;
   localparam logic [11:0] NZP_ALLN = 12'b100_100_100_100;
   simt_pc_if #(.PROGRAM_MEM_ADDR_BITS(8), .THREADS_PER_BLOCK(4)) bus ();
   simt_pc_unit #(.PROGRAM_MEM_ADDR_BITS(8), .THREADS_PER_BLOCK(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic ssy, input logic sync, input logic ret, input logic [2:0] nzp,
                        input logic [7:0] imm, input logic [11:0] tn);
      bus.enable = 1'b1;
      bus.core_state = 4'b0110;
      bus.decoded_ssy = ssy;
      bus.decoded_sync = sync;
      bus.decoded_ret = ret;
      bus.decoded_nzp = nzp;
      bus.decoded_immediate = imm;
      bus.thread_nzp = tn;
      #1;
   endtask
   task automatic op(input logic ssy, input logic sync, input logic ret, input logic [2:0] nzp,
                     input logic [7:0] imm, input logic [11:0] tn);
      drive(ssy, sync, ret, nzp, imm, tn);
      tick();
      bus.core_state = 4'b0000;
   endtask
   task automatic nop(input int n);
      for (int i = 0; i < n; i++) op(0, 0, 0, 3'b000, 8'd0, NZP_MIX);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask
   task automatic chk_state(input string tag, input logic [7:0] pc, input logic [3:0] em,
                            input logic [1:0] st);
      chk({tag, ".pc"}, bus.current_pc, pc);
      chk({tag, ".exec"}, bus.exec_mask, em);
      chk({tag, ".st"}, bus.div_state, st);
   endtask
   initial begin
      bus.enable = 1'b0;
      bus.core_state = 4'b0000;
      bus.decoded_ssy = 1'b0;
      bus.decoded_sync = 1'b0;
      bus.decoded_ret = 1'b0;
      bus.decoded_nzp = 3'b000;
      bus.decoded_immediate = 8'd0;
      bus.thread_nzp = NZP_MIX;
      bus.origin_mask = 4'b1111;
      tick();
      tick();
      reset = 1'b0;
      chk_state("rst", 8'd0, 4'b1111, 2'b00);
      chk("rst.done", bus.done, 0);
      chk("rst.nerr", bus.nest_error, 0);
      // divergence: taken {0,2}, fall {1,3}
      nop(3);
      drive(1, 0, 0, 3'b001, 8'd10, NZP_MIX);
      chk("div.cmask", bus.current_mask, 4'b0101);
      tick();
      bus.core_state = 4'b0000;
      chk_state("div.ssy", 8'd10, 4'b0101, 2'b01);
      nop(2);
      op(0, 1, 0, 3'b000, 8'd14, NZP_MIX);
      chk_state("div.sync1", 8'd4, 4'b1010, 2'b10);
      nop(5);
      chk("div.pc9", bus.current_pc, 8'd9);
      op(0, 1, 0, 3'b000, 8'd14, NZP_MIX);
      chk_state("div.sync2", 8'd14, 4'b1111, 2'b00);
      // all threads taken
      drive(1, 0, 0, 3'b001, 8'd40, NZP_ALLP);
      chk("all.cmask", bus.current_mask, 4'b1111);
      tick();
      bus.core_state = 4'b0000;
      chk_state("all.ssy", 8'd40, 4'b1111, 2'b01);
      op(0, 1, 0, 3'b000, 8'd20, NZP_ALLP);
      chk_state("all.sync", 8'd20, 4'b1111, 2'b00);
      // no thread taken, partial origin
      bus.origin_mask = 4'b1011;
      drive(1, 0, 0, 3'b001, 8'd50, NZP_ALLN);
      chk("none.cmask", bus.current_mask, 4'b0000);
      tick();
      bus.core_state = 4'b0000;
      chk_state("none.ssy", 8'd21, 4'b1011, 2'b10);
      op(0, 1, 0, 3'b000, 8'd30, NZP_ALLN);
      chk_state("none.sync", 8'd30, 4'b1011, 2'b00);
      bus.origin_mask = 4'b1111;
      // nested SSY while taken
      op(1, 0, 0, 3'b001, 8'd60, NZP_MIX);
      chk_state("nest.ssy1", 8'd60, 4'b0101, 2'b01);
      op(1, 0, 0, 3'b001, 8'd90, NZP_ALLP);
      chk_state("nest.ssy2", 8'd61, 4'b0101, 2'b01);
      chk("nest.nerr", bus.nest_error, 1);
      op(0, 1, 0, 3'b000, 8'd70, NZP_MIX);
      chk_state("nest.sync", 8'd31, 4'b1010, 2'b10);
      // RET in FALL
      do_reset();
      chk("ret.nerr0", bus.nest_error, 0);
      op(1, 0, 0, 3'b001, 8'd5, NZP_ALLN);
      chk_state("ret.ssy", 8'd1, 4'b1111, 2'b10);
      op(0, 0, 1, 3'b000, 8'd0, NZP_ALLN);
      chk_state("ret.fall", 8'd2, 4'b1111, 2'b10);
      chk("ret.nerr", bus.nest_error, 1);
      chk("ret.done", bus.done, 0);
      // wrap of pc and fall_pc
      do_reset();
      op(1, 0, 0, 3'b001, 8'd255, NZP_ALLP);
      chk_state("wrap.ssy", 8'd255, 4'b1111, 2'b01);
      op(0, 1, 0, 3'b000, 8'd255, NZP_ALLP);
      chk_state("wrap.sync", 8'd255, 4'b1111, 2'b00);
      op(1, 0, 0, 3'b001, 8'd100, NZP_MIX);
      chk_state("wrap.ssy2", 8'd100, 4'b0101, 2'b01);
      op(0, 1, 0, 3'b000, 8'd7, NZP_MIX);
      chk_state("wrap.fallpc", 8'd0, 4'b1010, 2'b10);
      op(0, 1, 0, 3'b000, 8'd255, NZP_MIX);
      chk_state("wrap.sync2", 8'd255, 4'b1111, 2'b00);
      nop(1);
      chk("wrap.pc", bus.current_pc, 8'd0);
      // gating
      drive(1, 0, 0, 3'b001, 8'd77, NZP_ALLP);
      bus.enable = 1'b0;
      tick();
      chk_state("gate.en", 8'd0, 4'b1111, 2'b00);
      bus.enable = 1'b1;
      bus.core_state = 4'b0101;
      tick();
      chk_state("gate.cs", 8'd0, 4'b1111, 2'b00);
      nop(2);
      op(0, 0, 1, 3'b000, 8'd0, NZP_ALLP);
      chk("done.set", bus.done, 1);
      chk("done.pc", bus.current_pc, 8'd2);
      op(1, 0, 0, 3'b001, 8'd77, NZP_ALLP);
      nop(1);
      chk_state("done.hold", 8'd2, 4'b1111, 2'b00);
      chk("done.sticky", bus.done, 1);
      // reset mid-divergence
      do_reset();
      chk("rst2.done", bus.done, 0);
      op(1, 0, 0, 3'b001, 8'd10, NZP_MIX);
      op(1, 0, 0, 3'b001, 8'd10, NZP_MIX);
      chk_state("mid.pre", 8'd11, 4'b0101, 2'b01);
      chk("mid.nerr", bus.nest_error, 1);
      do_reset();
      chk_state("mid.rst", 8'd0, 4'b1111, 2'b00);
      chk("mid.nerr0", bus.nest_error, 0);
      chk("mid.done0", bus.done, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/simt_pc_unit.md
# simt_pc_unit

Block-level program counter and divergence sequencer for one thread block. It computes the per-thread branch-taken set for the SIMT stack on SSY. It also owns the block PC and the active-thread execution mask, and sequences the taken path, the fall-through path and reconvergence across the SSY/SYNC pair. It sits between the decoder/per-thread NZP registers and the fetcher, alongside the SIMT stack.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, PC width
- THREADS_PER_BLOCK, 4, threads per block (T)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  block active
- core_state  in  4  core FSM state; 4'b0110 = EXECUTE
- decoded_ssy  in  1  current instruction is SSY
- decoded_sync  in  1  current instruction is SYNC
- decoded_ret  in  1  current instruction is RET
- decoded_nzp  in  3  branch condition mask of SSY
- decoded_immediate  in  PROGRAM_MEM_ADDR_BITS  SSY: taken-path start L; SYNC: reconvergence PC R
- thread_nzp  in  3*T  per-thread NZP flags, thread i at [3i+2:3i]
- origin_mask  in  T  threads enabled in this block
- current_pc  out  PROGRAM_MEM_ADDR_BITS  block PC
- current_mask  out  T  combinational taken set, to SIMT stack
- exec_mask  out  T  threads that execute the current instruction
- div_state  out  2  00 CONV, 01 TAKEN, 10 FALL
- done  out  1  sticky, block retired
- nest_error  out  1  sticky, illegal SSY/RET sequence

## Operation
- current_mask[i] = origin_mask[i] & |(thread_nzp[3i+2:3i] & decoded_nzp). This is pure combinational and independent of state.
- Internal registers: fall_pc (address width) and taken_saved (T).
- Update event: rising clk with core_state==4'b0110, enable==1 and done==0. Nothing changes otherwise.
- Decode priority: ssy > sync > ret > other.
- Required program layout: SSY L; fall code; SYNC R; L: taken code; SYNC R; R: continuation.
- SSY in CONV, taken = current_mask:
  - Taken nonzero: pc<=L, exec_mask<=taken, taken_saved<=taken, fall_pc<=pc+1, state TAKEN.
  - Taken zero: pc<=pc+1, exec_mask<=origin_mask, state FALL.
- SSY in TAKEN or FALL (nesting unsupported): nest_error<=1, pc<=pc+1, nothing else changes.
- SYNC in TAKEN:
  - origin_mask & ~taken_saved nonzero: pc<=fall_pc, exec_mask<=that mask, state FALL.
  - Otherwise: pc<=R, exec_mask<=origin_mask, state CONV.
- SYNC in FALL: pc<=R, exec_mask<=origin_mask, state CONV.
- SYNC in CONV: no-op, pc<=pc+1.
- RET in CONV: done<=1, pc holds.
- RET in TAKEN or FALL: nest_error<=1, pc<=pc+1.
- Other instructions: pc<=pc+1.
- PC arithmetic is modulo 2^PROGRAM_MEM_ADDR_BITS; all-ones wraps to 0, including fall_pc.

## Timing
- Reset values: current_pc=0, exec_mask=all ones, div_state=CONV, done=0, nest_error=0, fall_pc=0, taken_saved=0.
- All registered outputs update on the same edge as the SIMT stack. current_mask is valid in the EXECUTE cycle, before that edge.
- One update per EXECUTE cycle. enable=0 or a non-EXECUTE state freezes all state.
- Reset mid-divergence: returns to CONV at pc 0 with all state cleared on the next edge.
- done and nest_error clear only on reset. After done, no register changes.

## Test plan
- SSY divergence, T=4: origin=1111, nzp per thread {P,Z,P,N}, decoded_nzp=001, SSY at pc 3 with L=10, taken SYNC at 12 with R=14. Required:
  - At SSY: current_mask=0101, pc=10, exec_mask=0101, state TAKEN.
  - At SYNC at 12: pc=4, exec_mask=1010, state FALL.
  - At fall SYNC at 9 (R=14): pc=14, exec_mask=1111, state CONV.
- SSY, all threads taken: current_mask=1111, pc=L, state TAKEN. At SYNC R=20: pc=20, state CONV, FALL is never entered.
- SSY, no thread taken: current_mask=0000, pc=pc+1, state FALL, exec_mask=origin. At SYNC R=30: pc=30, state CONV.
- SSY while in TAKEN: nest_error=1, pc+1, state and exec_mask unchanged. RET in FALL also sets nest_error.
- PC wrap and gating:
  - Instruction at pc 255 → pc 0.
  - enable=0 or core_state≠0110 with SSY asserted → no change.
  - RET in CONV → done=1, and later EXECUTE cycles do not move pc.
- Reset mid-divergence in TAKEN → pc 0, exec_mask 1111, CONV, flags clear on the next edge.
